// File: rtl/trng_collector_pkg.sv
// Shared types and width helpers for the TRNG collector.
package trng_collector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        FAIL   = 2'd3
    } state_e;

    // Bits needed for a counter that must hold every value 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/trng_vn_corrector.sv
// Von Neumann debiaser: pairs strobed raw bits, emits the first bit of an unequal pair.
module trng_vn_corrector (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic sample_stb,
    input  logic sample,
    output logic emit,
    output logic emit_bit
);

    logic have_first;
    logic first_bit;

    // Hold the first bit of a pair; on the second, emit 0 for 01 and 1 for 10.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_first <= 1'b0;
            first_bit  <= 1'b0;
            emit       <= 1'b0;
            emit_bit   <= 1'b0;
        end else begin
            emit <= 1'b0;
            if (flush) begin
                have_first <= 1'b0;
            end else if (sample_stb) begin
                if (!have_first) begin
                    first_bit  <= sample;
                    have_first <= 1'b1;
                end else begin
                    have_first <= 1'b0;
                    if (first_bit != sample) begin
                        emit     <= 1'b1;
                        emit_bit <= first_bit;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/trng_collector.sv
// Collects raw TRNG bits: sync, health test, von Neumann correction, word packing.
module trng_collector
    import trng_collector_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned SAMPLE_DIV     = 4,
    parameter int unsigned WARMUP_SAMPLES = 64,
    parameter int unsigned REP_LIMIT      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic                  trng_in,
    output logic                  trng_en_o,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  health_fail_o,
    input  logic                  clear_fail_i
);

    localparam int unsigned DIV_W  = cnt_width(SAMPLE_DIV - 1);
    localparam int unsigned WARM_W = cnt_width(WARMUP_SAMPLES - 1);
    localparam int unsigned REP_W  = cnt_width(REP_LIMIT);
    localparam int unsigned BIT_W  = cnt_width(WORD_WIDTH);

    state_e state;
    state_e state_next;

    logic                  sync_q1;
    logic                  sync_q2;
    logic [DIV_W-1:0]      div_cnt;
    logic [WARM_W-1:0]     warm_cnt;
    logic [REP_W-1:0]      rep_cnt;
    logic [REP_W-1:0]      rep_cnt_next_c;
    logic                  prev_sample;
    logic                  active_c;
    logic                  strobe_c;
    logic                  warm_done_c;
    logic                  rep_hit_c;

    logic                  vn_emit;
    logic                  vn_bit;

    logic [WORD_WIDTH-1:0] shift_q;
    logic [BIT_W-1:0]      bit_cnt;
    logic [WORD_WIDTH-1:0] word_c;
    logic                  collecting_c;
    logic                  pending_c;
    logic                  accept_c;
    logic                  word_done_c;
    logic                  can_load_c;
    logic                  load_c;

    assign active_c    = (state == WARMUP) || (state == RUN);
    assign strobe_c    = active_c && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign warm_done_c = strobe_c && (warm_cnt == WARM_W'(WARMUP_SAMPLES - 1));
    assign rep_hit_c   = strobe_c && (rep_cnt_next_c == REP_W'(REP_LIMIT));

    // Two-flop synchroniser for the asynchronous oscillator output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= trng_in;
            sync_q2 <= sync_q1;
        end
    end

    // Sample divider; idle at zero while the oscillator is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!active_c || strobe_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Warm-up strobe counter, zeroed whenever we are not warming up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt <= '0;
        end else if (state != WARMUP) begin
            warm_cnt <= '0;
        end else if (strobe_c) begin
            warm_cnt <= warm_cnt + WARM_W'(1);
        end
    end

    // Next repetition count; zero means no previous sample since enable.
    always_comb begin
        rep_cnt_next_c = rep_cnt;
        if ((rep_cnt == '0) || (sync_q2 != prev_sample)) begin
            rep_cnt_next_c = REP_W'(1);
        end else if (rep_cnt != REP_W'(REP_LIMIT)) begin
            rep_cnt_next_c = rep_cnt + REP_W'(1);
        end
    end

    // Repetition-count health test state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt     <= '0;
            prev_sample <= 1'b0;
        end else if (!active_c) begin
            rep_cnt     <= '0;
        end else if (strobe_c) begin
            rep_cnt     <= rep_cnt_next_c;
            prev_sample <= sync_q2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; disable wins over a simultaneous health hit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable_i) state_next = WARMUP;
            end
            WARMUP: begin
                if (!enable_i)        state_next = IDLE;
                else if (rep_hit_c)   state_next = FAIL;
                else if (warm_done_c) state_next = RUN;
            end
            RUN: begin
                if (!enable_i)        state_next = IDLE;
                else if (rep_hit_c)   state_next = FAIL;
            end
            FAIL: begin
                if (clear_fail_i) state_next = enable_i ? WARMUP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered oscillator enable and sticky health flag follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trng_en_o     <= 1'b0;
            health_fail_o <= 1'b0;
        end else begin
            trng_en_o     <= (state_next == WARMUP) || (state_next == RUN);
            health_fail_o <= (state_next == FAIL);
        end
    end

    trng_vn_corrector u_vn (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (state != RUN),
        .sample_stb (strobe_c),
        .sample     (sync_q2),
        .emit       (vn_emit),
        .emit_bit   (vn_bit)
    );

    assign collecting_c = (state == RUN);
    assign pending_c    = (bit_cnt == BIT_W'(WORD_WIDTH));
    assign accept_c     = collecting_c && vn_emit && !pending_c;
    assign word_c       = {shift_q[WORD_WIDTH-2:0], vn_bit};
    assign word_done_c  = accept_c && (bit_cnt == BIT_W'(WORD_WIDTH - 1));
    assign can_load_c   = !valid_o || ready_i;
    // Only words finished while still collecting may reach the output.
    assign load_c       = (state_next == RUN) && can_load_c && (pending_c || word_done_c);

    // Packing shift register; a full word waits here while the output is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (!collecting_c) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (pending_c) begin
            if (load_c) bit_cnt <= '0;
        end else if (accept_c) begin
            if (load_c) begin
                bit_cnt <= '0;
            end else begin
                shift_q <= word_c;
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    // Output word register and valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (state_next == FAIL) begin
            valid_o <= 1'b0;
        end else if (load_c) begin
            data_o  <= pending_c ? shift_q : word_c;
            valid_o <= 1'b1;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule
